snn_timestep_scheduler: RTL and testbench

Time-multiplexed controller for a layer of leaky integrate-and-fire neurons sharing one membrane-update datapath. On each timestep tick it walks all neurons in index order and updates each neuron's stored potential from a configurable input mask. Inputs are external spikes plus the previous timestep's output spikes, which allows recurrence. It then publishes the new spike vector. It replaces per-neuron update logic in the spike network and owns the per-neuron connectivity configuration.

---
 rtl/snn_pkg.sv | 24 ++
 rtl/snn_timestep_scheduler_if.sv | 26 ++
 rtl/snn_timestep_scheduler_lif.sv | 61 ++++++
 rtl/snn_timestep_scheduler.sv | 141 ++++++++++++++
 tb/tb_snn_timestep_scheduler.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types, default neuron constants and width helpers for the LIF timestep scheduler.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } sched_state_t;

    localparam int DEF_V_REST   = 6;
    localparam int DEF_V_THRESH = 14;
    localparam int DEF_V_LEAK   = 1;
    localparam int DEF_K_SYN    = 1;

    function automatic int width_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Wide enough that V + K_SYN * (all sources active) never wraps.
    function automatic int sum_width(input int v_w, input int n_src, input int k_syn);
        return v_w + $clog2(n_src + 1) + $clog2(k_syn + 1) + 1;
    endfunction

endpackage

// File: rtl/snn_timestep_scheduler_if.sv
// Tick/config/spike bus of the timestep scheduler; master drives requests, slave is the scheduler.
interface snn_timestep_scheduler_if #(
    parameter int NUM_NEURONS = 8,
    parameter int NUM_INPUTS  = 3
);
    logic                                tick;
    logic [NUM_INPUTS-1:0]               spike_in;
    logic                                cfg_valid;
    logic                                cfg_ready;
    logic [$clog2(NUM_NEURONS)-1:0]      cfg_addr;
    logic [NUM_INPUTS+NUM_NEURONS-1:0]   cfg_mask;
    logic                                busy;
    logic [NUM_NEURONS-1:0]              spike_out;
    logic                                done;
    logic                                overrun;

    modport master (
        output tick, spike_in, cfg_valid, cfg_addr, cfg_mask,
        input  cfg_ready, busy, spike_out, done, overrun
    );

    modport slave (
        input  tick, spike_in, cfg_valid, cfg_addr, cfg_mask,
        output cfg_ready, busy, spike_out, done, overrun
    );
endinterface

// File: rtl/snn_timestep_scheduler_lif.sv
// Combinational leaky integrate-and-fire update for one neuron.
// SNN_REFRACTORY_EN adds the refractory counter ports and hold-off behaviour.
module lif_update
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int NUM_INPUTS  = 3,
    parameter int V_W         = 5,
    parameter int V_REST      = DEF_V_REST,
    parameter int V_THRESH    = DEF_V_THRESH,
    parameter int V_LEAK      = DEF_V_LEAK,
    parameter int K_SYN       = DEF_K_SYN,
    parameter int REFRAC_TS   = 2,
    localparam int NSRC       = NUM_INPUTS + NUM_NEURONS,
    localparam int RW         = width_min1(REFRAC_TS + 1)
) (
    input  logic [V_W-1:0]  v,
    input  logic [NSRC-1:0] mask,
    input  logic [NSRC-1:0] src,
`ifdef SNN_REFRACTORY_EN
    input  logic [RW-1:0]   refrac,
    output logic [RW-1:0]   refrac_next,
`endif
    output logic [V_W-1:0]  v_next,
    output logic            spike
);
    localparam int CW = $clog2(NSRC + 1);
    localparam int SW = sum_width(V_W, NSRC, K_SYN);

    logic [CW-1:0] cnt;
    logic [SW-1:0] sum;
    logic [SW-1:0] leaked;
    logic          fire;

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            cnt = cnt + CW'(mask[i] & src[i]);
        end
        sum    = SW'(v) + SW'(K_SYN) * SW'(cnt);
        leaked = (sum > SW'(V_LEAK)) ? sum - SW'(V_LEAK) : '0;
        fire   = (leaked >= SW'(V_THRESH));

        if (fire || leaked < SW'(V_REST)) begin
            v_next = V_W'(V_REST);
        end else begin
            v_next = leaked[V_W-1:0];
        end
        spike = fire;

`ifdef SNN_REFRACTORY_EN
        refrac_next = fire ? RW'(REFRAC_TS) : '0;
        if (refrac != '0) begin
            v_next      = V_W'(V_REST);
            spike       = 1'b0;
            refrac_next = refrac - RW'(1);
        end
`endif
    end

endmodule

// File: rtl/snn_timestep_scheduler.sv
// Time-multiplexed LIF layer: one lif_update datapath walks every neuron per tick.
// Optional SNN_REFRACTORY_EN keeps a per-neuron refractory counter.
module snn_timestep_scheduler
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = 8,
    parameter int NUM_INPUTS  = 3,
    parameter int V_W         = 5,
    parameter int V_REST      = DEF_V_REST,
    parameter int V_THRESH    = DEF_V_THRESH,
    parameter int V_LEAK      = DEF_V_LEAK,
    parameter int K_SYN       = DEF_K_SYN,
    parameter int REFRAC_TS   = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    snn_timestep_scheduler_if.slave       bus
);
    localparam int AW   = $clog2(NUM_NEURONS);
    localparam int NSRC = NUM_INPUTS + NUM_NEURONS;

    sched_state_t           state;
    logic [AW-1:0]          idx;
    logic [V_W-1:0]         v_mem    [NUM_NEURONS];
    logic [NSRC-1:0]        mask_mem [NUM_NEURONS];
    logic [NUM_INPUTS-1:0]  src_ext;
    logic [NUM_NEURONS-1:0] src_rec;
    logic [NUM_NEURONS-1:0] next_spikes;
    logic [NUM_NEURONS-1:0] spike_out_q;
    logic [NUM_NEURONS-1:0] spikes_final;
    logic                   done_q;
    logic                   busy_q;
    logic                   overrun_q;
    logic                   cfg_we;
    logic [V_W-1:0]         lif_v_next;
    logic                   lif_spike;

    assign bus.cfg_ready = !busy_q;
    assign bus.busy      = busy_q;
    assign bus.spike_out = spike_out_q;
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;

    assign cfg_we = bus.cfg_valid && !busy_q &&
                    ({1'b0, bus.cfg_addr} < (AW+1)'(NUM_NEURONS));

`ifdef SNN_REFRACTORY_EN
    localparam int RW = width_min1(REFRAC_TS + 1);
    logic [RW-1:0] refrac_mem [NUM_NEURONS];
    logic [RW-1:0] lif_refrac_next;
`endif

    lif_update #(
        .NUM_NEURONS (NUM_NEURONS),
        .NUM_INPUTS  (NUM_INPUTS),
        .V_W         (V_W),
        .V_REST      (V_REST),
        .V_THRESH    (V_THRESH),
        .V_LEAK      (V_LEAK),
        .K_SYN       (K_SYN),
        .REFRAC_TS   (REFRAC_TS)
    ) u_lif (
        .v           (v_mem[idx]),
        .mask        (mask_mem[idx]),
        .src         ({src_rec, src_ext}),
`ifdef SNN_REFRACTORY_EN
        .refrac      (refrac_mem[idx]),
        .refrac_next (lif_refrac_next),
`endif
        .v_next      (lif_v_next),
        .spike       (lif_spike)
    );

    // The last neuron's spike is merged here so spike_out and done are already
    // registered when the FSM enters DONE.
    always_comb begin
        spikes_final      = next_spikes;
        spikes_final[idx] = lif_spike;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            idx         <= '0;
            src_ext     <= '0;
            src_rec     <= '0;
            next_spikes <= '0;
            spike_out_q <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
                v_mem[i]    <= V_W'(V_REST);
                mask_mem[i] <= '0;
`ifdef SNN_REFRACTORY_EN
                refrac_mem[i] <= '0;
`endif
            end
        end else begin
            done_q <= 1'b0;
            if (cfg_we) begin
                mask_mem[bus.cfg_addr] <= bus.cfg_mask;
            end
            if (bus.tick && state != ST_IDLE) begin
                overrun_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.tick) begin
                        src_ext <= bus.spike_in;
                        src_rec <= spike_out_q;
                        idx     <= '0;
                        busy_q  <= 1'b1;
                        state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    v_mem[idx]       <= lif_v_next;
                    next_spikes[idx] <= lif_spike;
`ifdef SNN_REFRACTORY_EN
                    refrac_mem[idx]  <= lif_refrac_next;
`endif
                    if (idx == AW'(NUM_NEURONS - 1)) begin
                        spike_out_q <= spikes_final;
                        done_q      <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_timestep_scheduler.sv
// Self-checking bench for snn_timestep_scheduler (default build, SNN_REFRACTORY_EN undefined).
module tb_snn_timestep_scheduler;
    localparam int NN   = 8;
    localparam int NI   = 3;
    localparam int NSRC = NN + NI;

    logic clk;
    logic resetn;

    snn_timestep_scheduler_if #(.NUM_NEURONS(NN), .NUM_INPUTS(NI)) bus ();

    snn_timestep_scheduler #(
        .NUM_NEURONS (NN),
        .NUM_INPUTS  (NI),
        .V_W         (5),
        .V_REST      (6),
        .V_THRESH    (14),
        .V_LEAK      (1),
        .K_SYN       (1),
        .REFRAC_TS   (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [NI-1:0] spike_in;
        logic [NN-1:0] exp_spikes;
    } vec_t;

    vec_t          tab_rec [13];
    vec_t          tab_int [8];
    logic [NN-1:0] exp_q [$];
    logic [NN-1:0] mon_exp;
    int            n_cmp = 0;
    int            n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse consumes one pushed expectation.
    always @(negedge clk) begin
        if (resetn === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1, wanted no pulse");
            end else begin
                mon_exp = exp_q.pop_front();
                check("spike_out", 64'(bus.spike_out), 64'(mon_exp));
            end
        end
    end

    task automatic drive_idle();
        bus.tick      = 1'b0;
        bus.spike_in  = '0;
        bus.cfg_valid = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_mask  = '0;
    endtask

    // All sequencing tasks start and end 1 time unit after a rising edge.
    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [NSRC-1:0] mask);
        logic acc;
        acc           = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_mask  = mask;
        for (int k = 0; k < 40 && !acc; k++) begin
            acc = bus.cfg_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_cmp++;
            n_err++;
            $display("FAIL cfg_timeout: got cfg_ready=0 for 40 cycles, wanted 1");
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic tick_run(input logic [NI-1:0] sp, input logic [NN-1:0] exp);
        bus.tick     = 1'b1;
        bus.spike_in = sp;
        exp_q.push_back(exp);
        @(posedge clk);
        #1 bus.tick = 1'b0;
        repeat (NN + 1) @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;

        for (int i = 0; i < 13; i++) tab_rec[i] = '{3'b111, 8'h00};
        tab_rec[3].exp_spikes  = 8'h01;
        tab_rec[6].exp_spikes  = 8'h02;
        tab_rec[7].exp_spikes  = 8'h01;
        tab_rec[11].exp_spikes = 8'h01;
        tab_rec[12].exp_spikes = 8'h02;
        for (int i = 0; i < 8; i++) tab_int[i] = '{3'b011, 8'h00};
        tab_int[7].exp_spikes = 8'h01;

        drive_idle();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        check("rst_spike_out", 64'(bus.spike_out), 64'h0);
        check("rst_done",      64'(bus.done),      64'h0);
        check("rst_busy",      64'(bus.busy),      64'h0);
        check("rst_overrun",   64'(bus.overrun),   64'h0);
        check("rst_cfg_ready", 64'(bus.cfg_ready), 64'h1);

        // Neuron 0 integrates all inputs; neuron 1 also listens to neuron 0.
        cfg_write(3'd0, 11'h007);
        cfg_write(3'd1, 11'h00B);
        for (int i = 0; i < 13; i++) tick_run(tab_rec[i].spike_in, tab_rec[i].exp_spikes);

        do_reset();
        cfg_write(3'd0, 11'h003);
        for (int i = 0; i < 8; i++) tick_run(tab_int[i].spike_in, tab_int[i].exp_spikes);

        // Config request during a scan is held off until IDLE.
        do_reset();
        bus.tick     = 1'b1;
        bus.spike_in = 3'b111;
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1 bus.tick = 1'b0;
        bus.cfg_valid = 1'b1;
        bus.cfg_addr  = 3'd0;
        bus.cfg_mask  = 11'h007;
        check("cfg_ready_busy", 64'(bus.cfg_ready), 64'h0);
        check("busy_scan",      64'(bus.busy),      64'h1);
        @(posedge clk);
        #1;
        check("mask_held_busy", 64'(dut.mask_mem[0]), 64'h0);
        cfg_write(3'd0, 11'h007);
        check("mask_written_idle", 64'(dut.mask_mem[0]), 64'h007);
        tick_run(3'b111, 8'h00);
        tick_run(3'b111, 8'h00);
        tick_run(3'b111, 8'h00);
        tick_run(3'b111, 8'h01);

        // Second tick three cycles after acceptance is dropped.
        bus.tick     = 1'b1;
        bus.spike_in = 3'b111;
        exp_q.push_back(8'h00);
        @(posedge clk);
        #1 bus.tick = 1'b0;
        check("overrun_clear", 64'(bus.overrun), 64'h0);
        repeat (2) @(posedge clk);
        #1 bus.tick = 1'b1;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        cyc = 3;
        check("overrun_set", 64'(bus.overrun), 64'h1);
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("done_latency", 64'(cyc), 64'(NN));
        check("busy_in_done", 64'(bus.busy), 64'h1);
        @(posedge clk);
        #1;
        check("busy_after_done",  64'(bus.busy),      64'h0);
        check("ready_after_done", 64'(bus.cfg_ready), 64'h1);
        tick_run(3'b111, 8'h00);
        tick_run(3'b111, 8'h00);
        tick_run(3'b111, 8'h01);
        check("overrun_sticky", 64'(bus.overrun), 64'h1);

        // Reset while the scan sits at idx 3.
        bus.tick     = 1'b1;
        bus.spike_in = 3'b111;
        @(posedge clk);
        #1 bus.tick = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("scan_idx3", 64'(dut.idx), 64'h3);
        do_reset();
        repeat (NN + 4) @(posedge clk);
        #1;
        check("abort_spike_out", 64'(bus.spike_out), 64'h0);
        check("abort_overrun",   64'(bus.overrun),   64'h0);
        check("abort_busy",      64'(bus.busy),      64'h0);
        for (int i = 0; i < NN; i++) begin
            check($sformatf("abort_v%0d", i),    64'(dut.v_mem[i]),    64'h6);
            check($sformatf("abort_mask%0d", i), 64'(dut.mask_mem[i]), 64'h0);
        end
        tick_run(3'b111, 8'h00);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
